// File: rtl/pci_io_pkg.sv
// Shared constants and PERR# sequencer state encoding for the PCI pad-register layer.
package pci_io_pkg;

  localparam int PCI_PAR_GROUP   = 32;
  localparam int PCI_LANE_W      = 8;
  localparam int PCI_GROUP_LANES = PCI_PAR_GROUP / PCI_LANE_W;

  typedef enum logic [1:0] {
    PERR_IDLE     = 2'b00,
    PERR_DRIVE_LO = 2'b01,
    PERR_DRIVE_HI = 2'b10
  } perr_state_t;

endpackage

// File: rtl/pci_par_unit.sv
// Parity generator and checker for one 32-bit half of the AD bus.
// The generator works from the registered pad drive so PAR lands one enabled
// cycle behind its data. The checker latches the received phase's parity and
// compares it with PAR_I one cycle later, when the pad PAR for that phase is
// available.
module pci_par_unit
  import pci_io_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pci_ce,
  input  logic [PCI_PAR_GROUP-1:0]   ad_drv,
  input  logic [PCI_GROUP_LANES-1:0] cbe_drv,
  input  logic                       ad_t_lo,
  input  logic [PCI_PAR_GROUP-1:0]   ad_rcv,
  input  logic [PCI_GROUP_LANES-1:0] cbe_rcv,
  input  logic                       par_rcv,
  input  logic                       chk_en,
  output logic                       par_o,
  output logic                       par_t,
  output logic                       par_mismatch
);

  logic chk_par;
  logic chk_pend;

  // Outbound even parity and its tristate, both trailing the data by one enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_o <= 1'b0;
      par_t <= 1'b1;
    end else if (pci_ce) begin
      par_o <= (^ad_drv) ^ (^cbe_drv);
      par_t <= ad_t_lo;
    end
  end

  // Capture the parity of a data phase the core marks for checking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_par  <= 1'b0;
      chk_pend <= 1'b0;
    end else begin
      chk_pend <= chk_en;
      if (chk_en) begin
        chk_par <= (^ad_rcv) ^ (^cbe_rcv);
      end
    end
  end

  assign par_mismatch = chk_pend & (chk_par ^ par_rcv);

endmodule

// File: rtl/pci_io_regs.sv
// PCI pad-register layer: registers all inbound and outbound AD/CBE/PAR bits,
// generates outbound parity, checks inbound parity and sequences PERR#.
//
// PERR# sequencer states:
//   state          | meaning
//   PERR_IDLE      | PERR# released (T = 1)
//   PERR_DRIVE_LO  | PERR# driven low, a parity error was just registered
//   PERR_DRIVE_HI  | PERR# driven high for one cycle before release
module pci_io_regs
  import pci_io_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = DATA_W / PCI_LANE_W,
  localparam int PAR_W  = DATA_W / PCI_PAR_GROUP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pci_ce,
  input  logic [DATA_W-1:0] ad_pad_i,
  input  logic [LANES-1:0]  cbe_pad_i,
  input  logic [PAR_W-1:0]  par_pad_i,
  output logic [DATA_W-1:0] ad_pad_o,
  output logic [LANES-1:0]  ad_pad_t,
  output logic [LANES-1:0]  cbe_pad_o,
  output logic              cbe_pad_t,
  output logic [PAR_W-1:0]  par_pad_o,
  output logic [PAR_W-1:0]  par_pad_t,
  output logic              perr_pad_o,
  output logic              perr_pad_t,
  output logic [DATA_W-1:0] ad_i,
  output logic [LANES-1:0]  cbe_i,
  output logic [PAR_W-1:0]  par_i,
  input  logic [DATA_W-1:0] ad_o,
  input  logic [LANES-1:0]  cbe_o,
  input  logic [LANES-1:0]  oe_ad_n,
  input  logic              oe_cbe_n,
  input  logic              chk_en,
  input  logic              perr_en,
  output logic              par_err
);

  logic [PAR_W-1:0] par_mismatch;
  logic             err_any;
  perr_state_t      state_q;
  perr_state_t      state_d;

  // Inbound capture runs every cycle; the preset matches an idle pulled-up bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_i  <= '1;
      cbe_i <= '1;
      par_i <= '1;
    end else begin
      ad_i  <= ad_pad_i;
      cbe_i <= cbe_pad_i;
      par_i <= par_pad_i;
    end
  end

  // Outbound data and per-lane enables, frozen while pci_ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_pad_o  <= '0;
      cbe_pad_o <= '0;
      ad_pad_t  <= '1;
      cbe_pad_t <= 1'b1;
    end else if (pci_ce) begin
      ad_pad_o  <= ad_o;
      cbe_pad_o <= cbe_o;
      ad_pad_t  <= oe_ad_n;
      cbe_pad_t <= oe_cbe_n;
    end
  end

  for (genvar h = 0; h < PAR_W; h++) begin : g_par
    pci_par_unit u_par (
      .clk          (clk),
      .rst          (rst),
      .pci_ce       (pci_ce),
      .ad_drv       (ad_pad_o[h*PCI_PAR_GROUP +: PCI_PAR_GROUP]),
      .cbe_drv      (cbe_pad_o[h*PCI_GROUP_LANES +: PCI_GROUP_LANES]),
      .ad_t_lo      (ad_pad_t[h*PCI_GROUP_LANES]),
      .ad_rcv       (ad_i[h*PCI_PAR_GROUP +: PCI_PAR_GROUP]),
      .cbe_rcv      (cbe_i[h*PCI_GROUP_LANES +: PCI_GROUP_LANES]),
      .par_rcv      (par_i[h]),
      .chk_en       (chk_en),
      .par_o        (par_pad_o[h]),
      .par_t        (par_pad_t[h]),
      .par_mismatch (par_mismatch[h])
    );
  end

  assign err_any = |par_mismatch;

  // Parity error pulse is reported regardless of the parity error response bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= err_any;
    end
  end

  // PERR# sequencer state register; not gated by pci_ce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PERR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and PERR# pad drive; once started the sequence ignores perr_en.
  always_comb begin
    state_d    = state_q;
    perr_pad_o = 1'b1;
    perr_pad_t = 1'b1;
    case (state_q)
      PERR_IDLE: begin
        if (err_any && perr_en) begin
          state_d = PERR_DRIVE_LO;
        end
      end
      PERR_DRIVE_LO: begin
        perr_pad_o = 1'b0;
        perr_pad_t = 1'b0;
        state_d    = err_any ? PERR_DRIVE_LO : PERR_DRIVE_HI;
      end
      PERR_DRIVE_HI: begin
        perr_pad_t = 1'b0;
        state_d    = err_any ? PERR_DRIVE_LO : PERR_IDLE;
      end
      default: begin
        state_d = PERR_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pci_io_regs.sv
// Bench for pci_io_regs: a 32-bit and a 64-bit instance share stimulus; a
// history-based reference model predicts every output each cycle.
module tb_pci_io_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pci_ce, chk_en, perr_en, oe_cbe_n;
  logic [63:0] ad_pad_i, ad_o;
  logic [7:0]  cbe_pad_i, cbe_o, oe_ad_n;
  logic [1:0]  par_pad_i;

  logic [31:0] ad_pad_o_32, ad_i_32;
  logic [3:0]  ad_pad_t_32, cbe_pad_o_32, cbe_i_32;
  logic        cbe_pad_t_32, par_pad_o_32, par_pad_t_32, par_i_32;
  logic        perr_pad_o_32, perr_pad_t_32, par_err_32;

  logic [63:0] ad_pad_o_64, ad_i_64;
  logic [7:0]  ad_pad_t_64, cbe_pad_o_64, cbe_i_64;
  logic        cbe_pad_t_64;
  logic [1:0]  par_pad_o_64, par_pad_t_64, par_i_64;
  logic        perr_pad_o_64, perr_pad_t_64, par_err_64;

  pci_io_regs #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .pci_ce(pci_ce),
    .ad_pad_i(ad_pad_i[31:0]), .cbe_pad_i(cbe_pad_i[3:0]), .par_pad_i(par_pad_i[0]),
    .ad_pad_o(ad_pad_o_32), .ad_pad_t(ad_pad_t_32), .cbe_pad_o(cbe_pad_o_32),
    .cbe_pad_t(cbe_pad_t_32), .par_pad_o(par_pad_o_32), .par_pad_t(par_pad_t_32),
    .perr_pad_o(perr_pad_o_32), .perr_pad_t(perr_pad_t_32),
    .ad_i(ad_i_32), .cbe_i(cbe_i_32), .par_i(par_i_32),
    .ad_o(ad_o[31:0]), .cbe_o(cbe_o[3:0]), .oe_ad_n(oe_ad_n[3:0]), .oe_cbe_n(oe_cbe_n),
    .chk_en(chk_en), .perr_en(perr_en), .par_err(par_err_32)
  );

  pci_io_regs #(.DATA_W(64)) dut64 (
    .clk(clk), .rst(rst), .pci_ce(pci_ce),
    .ad_pad_i(ad_pad_i), .cbe_pad_i(cbe_pad_i), .par_pad_i(par_pad_i),
    .ad_pad_o(ad_pad_o_64), .ad_pad_t(ad_pad_t_64), .cbe_pad_o(cbe_pad_o_64),
    .cbe_pad_t(cbe_pad_t_64), .par_pad_o(par_pad_o_64), .par_pad_t(par_pad_t_64),
    .perr_pad_o(perr_pad_o_64), .perr_pad_t(perr_pad_t_64),
    .ad_i(ad_i_64), .cbe_i(cbe_i_64), .par_i(par_i_64),
    .ad_o(ad_o), .cbe_o(cbe_o), .oe_ad_n(oe_ad_n), .oe_cbe_n(oe_cbe_n),
    .chk_en(chk_en), .perr_en(perr_en), .par_err(par_err_64)
  );

  // Reference model: h_*[0] = inputs sampled at the latest edge, [1] the edge before, ...
  logic [63:0] h_ad [3];
  logic [7:0]  h_cbe [3];
  logic [1:0]  h_par [3];
  logic        h_chk [3];
  logic        h_pen [3];
  logic [63:0] cur_ad, prev_ad;
  logic [7:0]  cur_cbe, prev_cbe, cur_oe, prev_oe;
  logic        cur_oec;
  logic        err32, err64, lo32, hi32, lo64, hi64;

  int checks   = 0;
  int failures = 0;

  function automatic logic half_par(input logic [63:0] ad, input logic [7:0] cbe, input int h);
    return (^ad[h*32 +: 32]) ^ (^cbe[h*4 +: 4]);
  endfunction

  // A phase checked in cycle k used the pad data of cycle k-1 and the pad PAR of cycle k.
  function automatic logic exp_err(input int halves);
    logic e;
    e = 1'b0;
    if (h_chk[1]) begin
      for (int h = 0; h < halves; h++) begin
        if (half_par(h_ad[2], h_cbe[2], h) != h_par[1][h]) e = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      h_ad[i] = '1; h_cbe[i] = '1; h_par[i] = '1; h_chk[i] = 1'b0; h_pen[i] = 1'b0;
    end
    cur_ad = '0; prev_ad = '0; cur_cbe = '0; prev_cbe = '0;
    cur_oe = '1; prev_oe = '1; cur_oec = 1'b1;
    err32 = 1'b0; err64 = 1'b0;
    lo32 = 1'b0; hi32 = 1'b0; lo64 = 1'b0; hi64 = 1'b0;
  endtask

  task automatic model_edge();
    logic lo_n;
    for (int i = 2; i > 0; i--) begin
      h_ad[i] = h_ad[i-1]; h_cbe[i] = h_cbe[i-1]; h_par[i] = h_par[i-1];
      h_chk[i] = h_chk[i-1]; h_pen[i] = h_pen[i-1];
    end
    h_ad[0] = ad_pad_i; h_cbe[0] = cbe_pad_i; h_par[0] = par_pad_i;
    h_chk[0] = chk_en; h_pen[0] = perr_en;
    if (pci_ce) begin
      prev_ad = cur_ad; prev_cbe = cur_cbe; prev_oe = cur_oe;
      cur_ad = ad_o; cur_cbe = cbe_o; cur_oe = oe_ad_n; cur_oec = oe_cbe_n;
    end
    err32 = exp_err(1);
    err64 = exp_err(2);
    // PERR# low on each error once a sequence is enabled or running, high for one cycle after.
    lo_n = err32 && (h_pen[0] || lo32 || hi32);
    hi32 = !lo_n && lo32;
    lo32 = lo_n;
    lo_n = err64 && (h_pen[0] || lo64 || hi64);
    hi64 = !lo_n && lo64;
    lo64 = lo_n;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("ad_i_32",       64'(ad_i_32),       64'(h_ad[0][31:0]));
    check("cbe_i_32",      64'(cbe_i_32),      64'(h_cbe[0][3:0]));
    check("par_i_32",      64'(par_i_32),      64'(h_par[0][0]));
    check("ad_pad_o_32",   64'(ad_pad_o_32),   64'(cur_ad[31:0]));
    check("ad_pad_t_32",   64'(ad_pad_t_32),   64'(cur_oe[3:0]));
    check("cbe_pad_o_32",  64'(cbe_pad_o_32),  64'(cur_cbe[3:0]));
    check("cbe_pad_t_32",  64'(cbe_pad_t_32),  64'(cur_oec));
    check("par_pad_o_32",  64'(par_pad_o_32),  64'(half_par(prev_ad, prev_cbe, 0)));
    check("par_pad_t_32",  64'(par_pad_t_32),  64'(prev_oe[0]));
    check("par_err_32",    64'(par_err_32),    64'(err32));
    check("perr_pad_o_32", 64'(perr_pad_o_32), 64'(!lo32));
    check("perr_pad_t_32", 64'(perr_pad_t_32), 64'(!(lo32 || hi32)));
    check("ad_i_64",       ad_i_64,            h_ad[0]);
    check("cbe_i_64",      64'(cbe_i_64),      64'(h_cbe[0]));
    check("par_i_64",      64'(par_i_64),      64'(h_par[0]));
    check("ad_pad_o_64",   ad_pad_o_64,        cur_ad);
    check("ad_pad_t_64",   64'(ad_pad_t_64),   64'(cur_oe));
    check("cbe_pad_o_64",  64'(cbe_pad_o_64),  64'(cur_cbe));
    check("cbe_pad_t_64",  64'(cbe_pad_t_64),  64'(cur_oec));
    check("par_pad_o_64",  64'(par_pad_o_64),
          64'({half_par(prev_ad, prev_cbe, 1), half_par(prev_ad, prev_cbe, 0)}));
    check("par_pad_t_64",  64'(par_pad_t_64),  64'({prev_oe[4], prev_oe[0]}));
    check("par_err_64",    64'(par_err_64),    64'(err64));
    check("perr_pad_o_64", 64'(perr_pad_o_64), 64'(!lo64));
    check("perr_pad_t_64", 64'(perr_pad_t_64), 64'(!(lo64 || hi64)));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    compare_all();
  endtask

  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_perr_t_64", 64'(perr_pad_t_64), 64'd1);
    check("rst_async_perr_o_64", 64'(perr_pad_o_64), 64'd1);
    model_reset();
    compare_all();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pci_ce = 1'b0; chk_en = 1'b0; perr_en = 1'b0; oe_cbe_n = 1'b1;
    ad_pad_i = '0; ad_o = '0; cbe_pad_i = '0; cbe_o = '0; oe_ad_n = '1; par_pad_i = '0;
    model_reset();

    // Reset values
    step(); step();
    check("rst_ad_i",     64'(ad_i_32),       64'hFFFF_FFFF);
    check("rst_cbe_i",    64'(cbe_i_32),      64'hF);
    check("rst_ad_t",     64'(ad_pad_t_32),   64'hF);
    check("rst_cbe_t",    64'(cbe_pad_t_32),  64'd1);
    check("rst_par_t",    64'(par_pad_t_32),  64'd1);
    check("rst_perr_t",   64'(perr_pad_t_32), 64'd1);
    check("rst_par_err",  64'(par_err_32),    64'd0);
    rst = 1'b0;

    // Outbound data then parity one cycle later
    pci_ce = 1'b1; ad_o = 64'h1; cbe_o = '0; oe_ad_n = '0; oe_cbe_n = 1'b0; perr_en = 1'b1;
    step();
    check("out_ad_lat1",  64'(ad_pad_o_32),  64'h1);
    step();
    check("out_par_lat2", 64'(par_pad_o_32), 64'd1);
    check("out_par_t",    64'(par_pad_t_32), 64'd0);

    // Single parity error and PERR# sequence
    ad_pad_i = 64'hF; cbe_pad_i = '0; par_pad_i = 2'b00;
    step();
    par_pad_i = 2'b01; chk_en = 1'b1;
    step();
    chk_en = 1'b0; par_pad_i = 2'b00;
    step();
    check("err1_pulse",   64'(par_err_32),    64'd1);
    check("err1_perr_lo", 64'(perr_pad_o_32), 64'd0);
    check("err1_perr_t",  64'(perr_pad_t_32), 64'd0);
    step();
    check("err1_pulse_end", 64'(par_err_32),    64'd0);
    check("err1_perr_hi",   64'(perr_pad_o_32), 64'd1);
    check("err1_perr_hi_t", 64'(perr_pad_t_32), 64'd0);
    step();
    check("err1_release", 64'(perr_pad_t_32), 64'd1);

    // Back-to-back errors
    ad_pad_i = 64'h1; par_pad_i = 2'b00;
    step();
    ad_pad_i = 64'h3; par_pad_i = 2'b00; chk_en = 1'b1;
    step();
    ad_pad_i = 64'h0; par_pad_i = 2'b01;
    step();
    check("err2_a_pulse", 64'(par_err_32),    64'd1);
    check("err2_a_lo",    64'(perr_pad_o_32), 64'd0);
    chk_en = 1'b0; par_pad_i = 2'b00;
    step();
    check("err2_b_pulse", 64'(par_err_32),    64'd1);
    check("err2_b_lo",    64'(perr_pad_o_32), 64'd0);
    step();
    check("err2_hi",      64'(perr_pad_o_32), 64'd1);
    check("err2_hi_t",    64'(perr_pad_t_32), 64'd0);
    step();
    check("err2_release", 64'(perr_pad_t_32), 64'd1);

    // pci_ce freeze and resume
    pci_ce = 1'b0; ad_o = 64'hA5A5_A5A5;
    step();
    check("freeze_ad",  64'(ad_pad_o_32),  64'h1);
    check("freeze_par", 64'(par_pad_o_32), 64'd1);
    ad_o = 64'h1234_5678;
    step();
    check("freeze_ad2", 64'(ad_pad_o_32),  64'h1);
    pci_ce = 1'b1;
    step();
    check("resume_ad",  64'(ad_pad_o_32),  64'h1234_5678);
    step();
    check("resume_par", 64'(par_pad_o_32), 64'd1);

    // 64-bit upper-half error, then reset during DRIVE_LO
    ad_pad_i = 64'h1_0000_0000; cbe_pad_i = '0; par_pad_i = 2'b00;
    step();
    chk_en = 1'b1;
    step();
    chk_en = 1'b0;
    step();
    check("hi_err_64",  64'(par_err_64),    64'd1);
    check("hi_err_32",  64'(par_err_32),    64'd0);
    check("hi_perr_lo", 64'(perr_pad_o_64), 64'd0);
    mid_reset();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      pci_ce   = ($urandom_range(0, 3) != 0);
      ad_o     = {$urandom, $urandom};
      cbe_o    = 8'($urandom);
      oe_ad_n  = 8'($urandom);
      oe_cbe_n = 1'($urandom);
      par_pad_i = {half_par(ad_pad_i, cbe_pad_i, 1), half_par(ad_pad_i, cbe_pad_i, 0)}
                  ^ (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
      ad_pad_i  = {$urandom, $urandom};
      cbe_pad_i = 8'($urandom);
      chk_en    = 1'($urandom_range(0, 1));
      perr_en   = ($urandom_range(0, 9) != 0);
      step();
      if (n == 150 || n == 300) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
